// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage pipelined floating-point compare/select unit.
// Ops: 0=EQ, 1=LT, 2=LE, 3=MIN, 4=MAX. Codes 5-7 are reserved and return y=0 with invalid=1.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake for x1, x2 and op
//   x1, x2 [W-1:0]        operands {sign, exp, man}, where W = 1+EXP_W+MAN_W
//   op [2:0]              operation select
//   out_valid/out_ready   output handshake for y and invalid
//   y [W-1:0]             compare bit (zero-extended) or the selected operand
//   invalid               invalid-operation flag, qualified by out_valid
module fcmp_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   x1,
   input  logic [EXP_W+MAN_W:0]   x2,
   input  logic [2:0]             op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   y,
   output logic                   invalid
);

   localparam int unsigned W = 1 + EXP_W + MAN_W;

   localparam logic [2:0] OP_EQ  = 3'd0;
   localparam logic [2:0] OP_LT  = 3'd1;
   localparam logic [2:0] OP_LE  = 3'd2;
   localparam logic [2:0] OP_MIN = 3'd3;
   localparam logic [2:0] OP_MAX = 3'd4;

   localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // Zero exponent (zero or subnormal) flushes to +0.
   function automatic logic [W-1:0] flush(input logic [W-1:0] x);
      return (x[W-2 -: EXP_W] == '0) ? '0 : x;
   endfunction

   // Key whose unsigned order matches the numeric order of non-NaN values.
   function automatic logic [W-1:0] mkey(input logic [W-1:0] f);
      return f[W-1] ? {1'b0, ~f[W-2:0]} : {1'b1, f[W-2:0]};
   endfunction

   function automatic logic is_nan(input logic [W-1:0] x);
      return (x[W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] != '0);
   endfunction

   function automatic logic is_snan(input logic [W-1:0] x);
      return is_nan(x) && !x[MAN_W-1];
   endfunction

   // Stage 1 state
   logic           s1_valid_q, s1_valid_d;
   logic [W-1:0]   f1_q, f1_d, f2_q, f2_d;
   logic [W-1:0]   k1_q, k1_d, k2_q, k2_d;
   logic           nan1_q, nan1_d, nan2_q, nan2_d;
   logic           snan1_q, snan1_d, snan2_q, snan2_d;
   logic [2:0]     op_q, op_d;

   // Stage 2 state
   logic           s2_valid_q, s2_valid_d;
   logic [W-1:0]   y_q, y_d;
   logic           inv_q, inv_d;

   logic           s2_ready;
   logic           in_fire;
   logic           s1_adv;

   // Handshake: a slot can take new data when it is empty or is draining this cycle.
   assign s2_ready = ~s2_valid_q | out_ready;
   assign in_ready = ~s1_valid_q | s2_ready;
   assign in_fire  = in_valid & in_ready;
   assign s1_adv   = s1_valid_q & s2_ready;

   // Stage 1: decode operands into flushed values, ordering keys and NaN class.
   always_comb begin
      s1_valid_d = s1_valid_q;
      f1_d       = f1_q;
      f2_d       = f2_q;
      k1_d       = k1_q;
      k2_d       = k2_q;
      nan1_d     = nan1_q;
      nan2_d     = nan2_q;
      snan1_d    = snan1_q;
      snan2_d    = snan2_q;
      op_d       = op_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         f1_d       = flush(x1);
         f2_d       = flush(x2);
         k1_d       = mkey(flush(x1));
         k2_d       = mkey(flush(x2));
         nan1_d     = is_nan(x1);
         nan2_d     = is_nan(x2);
         snan1_d    = is_snan(x1);
         snan2_d    = is_snan(x2);
         op_d       = op;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage 2: compare the keys and select the result.
   always_comb begin
      logic any_nan, any_snan, eq, lt;
      any_nan    = nan1_q | nan2_q;
      any_snan   = snan1_q | snan2_q;
      eq         = (k1_q == k2_q);
      lt         = (k1_q < k2_q);
      s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
      y_d        = y_q;
      inv_d      = inv_q;
      if (s1_adv) begin
         unique case (op_q)
            OP_EQ: begin
               y_d   = W'(eq & ~any_nan);
               inv_d = any_snan;
            end
            OP_LT: begin
               y_d   = W'(lt & ~any_nan);
               inv_d = any_nan;
            end
            OP_LE: begin
               y_d   = W'((lt | eq) & ~any_nan);
               inv_d = any_nan;
            end
            OP_MIN, OP_MAX: begin
               inv_d = any_snan;
               if (nan1_q && nan2_q)      y_d = CANON_NAN;
               else if (nan1_q)           y_d = f2_q;
               else if (nan2_q)           y_d = f1_q;
               // On a tie x1 is returned.
               else if (op_q == OP_MIN)   y_d = (lt | eq) ? f1_q : f2_q;
               else                       y_d = lt ? f2_q : f1_q;
            end
            default: begin
               y_d   = '0;
               inv_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         f1_q       <= '0;
         f2_q       <= '0;
         k1_q       <= '0;
         k2_q       <= '0;
         nan1_q     <= 1'b0;
         nan2_q     <= 1'b0;
         snan1_q    <= 1'b0;
         snan2_q    <= 1'b0;
         op_q       <= '0;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         inv_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         f1_q       <= f1_d;
         f2_q       <= f2_d;
         k1_q       <= k1_d;
         k2_q       <= k2_d;
         nan1_q     <= nan1_d;
         nan2_q     <= nan2_d;
         snan1_q    <= snan1_d;
         snan2_q    <= snan2_d;
         op_q       <= op_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         inv_q      <= inv_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign y         = y_q;
   assign invalid   = inv_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: directed vector table, backpressure and
// reset sequences, randomized streaming against a value-level model, and a
// double-precision instance.
module tb_fcmp_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, invalid;
   logic [31:0] x1, x2, y;
   logic [2:0]  op;

   logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_invalid;
   logic [63:0] d_x1, d_x2, d_y;
   logic [2:0]  d_op;

   always #5 clk = ~clk;

   fcmp_pipe u_sp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .x2(x2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .invalid(invalid));

   fcmp_pipe #(.EXP_W(11), .MAN_W(52)) u_dp (
      .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .x1(d_x1), .x2(d_x2), .op(d_op), .out_valid(d_out_valid), .out_ready(d_out_ready),
      .y(d_y), .invalid(d_invalid));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (single precision) ----------------
   function automatic logic [31:0] m_flush(input logic [31:0] x);
      return (x[30:23] == 8'd0) ? 32'd0 : x;
   endfunction
   function automatic bit m_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction
   function automatic bit m_snan(input logic [31:0] x);
      return m_nan(x) && !x[22];
   endfunction
   // Numeric a<b for non-NaN flushed values using sign/magnitude reasoning.
   function automatic bit m_less(input logic [31:0] a, input logic [31:0] b);
      if (a == b) return 1'b0;
      if (a[31] != b[31]) return a[31];
      if (!a[31]) return a[30:0] < b[30:0];
      return a[30:0] > b[30:0];
   endfunction
   // Returns {invalid, y}.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
      logic [31:0] fa, fb;
      bit na, nb, sn, eqv, ltv;
      fa = m_flush(a); fb = m_flush(b);
      na = m_nan(a); nb = m_nan(b);
      sn = m_snan(a) || m_snan(b);
      eqv = !na && !nb && (fa == fb);
      ltv = !na && !nb && m_less(fa, fb);
      case (o)
         3'd0: return {sn, 31'd0, eqv};
         3'd1: return {na || nb, 31'd0, ltv};
         3'd2: return {na || nb, 31'd0, ltv || eqv};
         3'd3, 3'd4: begin
            if (na && nb) return {sn, 32'h7FC00000};
            if (na) return {sn, fb};
            if (nb) return {sn, fa};
            if (o == 3'd3) return {sn, m_less(fb, fa) ? fb : fa};
            return {sn, m_less(fa, fb) ? fb : fa};
         end
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 9))
         0: v = {v[31], 31'd0};
         1: v = {v[31], 8'd0, v[22:0]};
         2: v = {v[31], 8'hFF, 23'd0};
         3: v = {v[31], 8'hFF, 1'b1, v[21:0]};
         4: v = {v[31], 8'hFF, 2'b01, v[20:0]};
         default: v = {v[31], 8'($urandom_range(125, 129)), 20'd0, v[2:0]};
      endcase
      return v;
   endfunction

   // ---------------- cycle stepping with scoreboard ----------------
   logic [32:0] sb_q[$];
   bit          prev_stall = 1'b0;
   logic [31:0] prev_y;
   logic        prev_inv;
   bit          last_ir, last_ov, last_in_fire;
   int          n_out = 0;

   // Called at posedge+1 with inputs already set; returns at next posedge+1.
   task automatic step();
      logic [32:0] e;
      #1;
      last_ir      = in_ready;
      last_ov      = out_valid;
      last_in_fire = in_valid && in_ready;
      if (prev_stall) begin
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_y", 64'(y), 64'(prev_y));
         chk("hold_invalid", 64'(invalid), 64'(prev_inv));
      end
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'd0);
         end else begin
            e = sb_q.pop_front();
            n_out++;
            chk("stream_y", 64'(y), 64'(e[31:0]));
            chk("stream_invalid", 64'(invalid), 64'(e[32]));
         end
      end
      if (last_in_fire) sb_q.push_back(model(x1, x2, op));
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_inv   = invalid;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  o;
      logic [31:0] ey;
      logic        einv;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] bp_a[4];
      logic [2:0]  bp_o[4];
      int          idx;
      bit          pend;

      vecs = '{
         '{32'h3F800000, 32'h40000000, 3'd2, 32'h1,        1'b0},
         '{32'h40000000, 32'h3F800000, 3'd1, 32'h0,        1'b0},
         '{32'h80000000, 32'h00000001, 3'd0, 32'h1,        1'b0},
         '{32'h80000000, 32'h00000001, 3'd3, 32'h0,        1'b0},
         '{32'h7FC00000, 32'h3F800000, 3'd1, 32'h0,        1'b1},
         '{32'h7FC00000, 32'h3F800000, 3'd0, 32'h0,        1'b0},
         '{32'h7F800001, 32'h3F800000, 3'd0, 32'h0,        1'b1},
         '{32'h7FC00000, 32'hC0000000, 3'd4, 32'hC0000000, 1'b0},
         '{32'h7FC00000, 32'h7FC00001, 3'd4, 32'h7FC00000, 1'b0},
         '{32'hFF800000, 32'hBF800000, 3'd3, 32'hFF800000, 1'b0},
         '{32'h3F800000, 32'h40000000, 3'd5, 32'h0,        1'b1},
         '{32'hBF800000, 32'h3F800000, 3'd3, 32'hBF800000, 1'b0},
         '{32'h7F800001, 32'h3F800000, 3'd4, 32'h3F800000, 1'b1},
         '{32'hC0000000, 32'hBF800000, 3'd2, 32'h1,        1'b0},
         '{32'h7F800000, 32'h7F7FFFFF, 3'd1, 32'h0,        1'b0},
         '{32'h80000005, 32'h80000000, 3'd4, 32'h0,        1'b0},
         '{32'h80000000, 32'h00000000, 3'd1, 32'h0,        1'b0},
         '{32'h40400000, 32'h40400000, 3'd2, 32'h1,        1'b0}
      };

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0; op = '0;
      d_in_valid = 1'b0; d_out_ready = 1'b1; d_x1 = '0; d_x2 = '0; d_op = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_y", 64'(y), 64'd0);
      chk("reset_invalid", 64'(invalid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors, checking exact 2-cycle latency.
      out_ready = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         x1 = vecs[i].a; x2 = vecs[i].b; op = vecs[i].o; in_valid = 1'b1;
         #1 chk("vec_in_ready", 64'(in_ready), 64'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         #1 chk($sformatf("vec%0d_lat1_valid", i), 64'(out_valid), 64'd0);
         @(posedge clk); #1;
         #1;
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_y", i), 64'(y), 64'(vecs[i].ey));
         chk($sformatf("vec%0d_invalid", i), 64'(invalid), 64'(vecs[i].einv));
         @(posedge clk); #1;
      end

      // Backpressure: 4 back-to-back ops, out_ready low for cycles 0..4.
      bp_a = '{32'h3F800000, 32'hC0000000, 32'h7FC00000, 32'h00000003};
      bp_o = '{3'd2, 3'd3, 3'd4, 3'd0};
      idx = 0; n_out = 0; prev_stall = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (idx < 4);
         if (idx < 4) begin
            x1 = bp_a[idx]; x2 = 32'h40000000; op = bp_o[idx];
         end
         step();
         if (last_in_fire) idx++;
         if (cyc == 2) begin
            chk("bp_in_ready_drop", 64'(last_ir), 64'd0);
            chk("bp_accepted_before_drop", 64'(idx), 64'd2);
         end
         if (cyc == 4) chk("bp_out_valid_stalled", 64'(last_ov), 64'd1);
      end
      in_valid = 1'b0;
      chk("bp_all_results", 64'(n_out), 64'd4);
      chk("bp_queue_empty", 64'(sb_q.size()), 64'd0);

      // Reset with two ops in flight.
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         x1 = 32'h3F800000; x2 = 32'h3F800000; op = 3'd0; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1 chk("rst_out_valid_immediate", 64'(out_valid), 64'd0);
      sb_q.delete();
      prev_stall = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("post_rst_no_output", 64'(last_ov), 64'd0);
      end

      // Randomized streaming with random backpressure.
      pend = 1'b0; n_out = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!pend && ($urandom_range(0, 3) != 0)) begin
            x1 = rand_operand();
            x2 = ($urandom_range(0, 5) == 0) ? x1 : rand_operand();
            op = 3'($urandom_range(0, 7));
            pend = 1'b1;
         end
         in_valid  = pend;
         out_ready = ($urandom_range(0, 9) < 7);
         step();
         if (last_in_fire) pend = 1'b0;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 10 && sb_q.size() != 0; k++) step();
      chk("rand_drain_empty", 64'(sb_q.size()), 64'd0);

      // Double-precision instance.
      d_x1 = 64'h3FF0000000000000; d_x2 = 64'h4000000000000000; d_op = 3'd2; d_in_valid = 1'b1;
      @(posedge clk); #1;
      d_x1 = 64'h3FF0000000000000; d_x2 = 64'hC000000000000000; d_op = 3'd3;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      #1;
      chk("dp_le_valid", 64'(d_out_valid), 64'd1);
      chk("dp_le_y", d_y, 64'd1);
      chk("dp_le_invalid", 64'(d_invalid), 64'd0);
      @(posedge clk); #2;
      chk("dp_min_valid", 64'(d_out_valid), 64'd1);
      chk("dp_min_y", d_y, 64'hC000000000000000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case the sequence stalls.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
